// File: rtl/mdu_seq_pkg.sv
// Shared multiply/divide encodings, sequencer state codes and default latencies.
package mdu_seq_pkg;

  typedef enum logic [1:0] {
    md_mult  = 2'd0,
    md_multu = 2'd1,
    md_div   = 2'd2,
    md_divu  = 2'd3
  } mdop_t;

  typedef enum logic {
    mdu_idle = 1'b0,
    mdu_run  = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply / divide core producing the HI/LO pair.
// Latency: zero cycles; the sequencer models the architectural delay.
// Backpressure: none, pure function of its inputs.
module mdu_calc
  import mdu_seq_pkg::*;
(
  input  logic [1:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] r_hi,
  output logic [31:0] r_lo,
  output logic        divz
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               ovf;
  logic        [31:0] dsr_s;
  logic        [31:0] dsr_u;
  logic signed [31:0] q_s;
  logic signed [31:0] rem_s;
  logic        [31:0] q_u;
  logic        [31:0] rem_u;

  assign divz = (b == 32'd0);
  assign ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Dividing by 1 instead gives exactly the architected 0x80000000 / -1 result
  // and keeps the divider away from zero divisors.
  assign dsr_s = (divz || ovf) ? 32'd1 : b;
  assign dsr_u = divz ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign q_s    = $signed(a) / $signed(dsr_s);
  assign rem_s  = $signed(a) % $signed(dsr_s);
  assign q_u    = a / dsr_u;
  assign rem_u  = a % dsr_u;

  always_comb begin
    r_hi = 32'd0;
    r_lo = 32'd0;
    case (mdop)
      md_mult: begin
        r_hi = prod_s[63:32];
        r_lo = prod_s[31:0];
      end
      md_multu: begin
        r_hi = prod_u[63:32];
        r_lo = prod_u[31:0];
      end
      md_div: begin
        r_hi = rem_s;
        r_lo = q_s;
      end
      default: begin
        r_hi = rem_u;
        r_lo = q_u;
      end
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// E-stage multiply/divide sequencer owning architectural HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, result visible the cycle after.
// Backpressure: stall holds D-stage MDU instructions while busy or issuing.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hiwe,
  input  logic        lowe,
  input  logic [31:0] wdata,
  input  logic        usemd_d,
  input  logic        kill,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state;
  mdu_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  hilo_t            pend;
  logic             p_divz;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             divz;
  logic             is_div;
  logic             issue;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;

  mdu_calc u_calc (
    .mdop (mdop),
    .a    (a),
    .b    (b),
    .r_hi (calc_hi),
    .r_lo (calc_lo),
    .divz (divz)
  );

  assign is_div = mdop[1];
  assign busy   = (state == mdu_run);
  assign stall  = usemd_d && (busy || start);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    issue    = 1'b0;
    commit   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    case (state)
      mdu_idle: begin
        // An issue takes priority over a same-cycle mthi/mtlo.
        if (start && !kill) begin
          issue    = 1'b1;
          cnt_nx   = is_div ? DIV_LOAD : MULT_LOAD;
          state_nx = mdu_run;
        end else begin
          wr_hi = hiwe && !kill;
          wr_lo = lowe && !kill;
        end
      end
      mdu_run: begin
        // kill is deliberately ignored here: an in-flight op always completes.
        if (cnt == '0) begin
          commit   = 1'b1;
          state_nx = mdu_idle;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = mdu_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= mdu_idle;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      p_divz <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      if (issue) begin
        pend.hi <= calc_hi;
        pend.lo <= calc_lo;
        p_divz  <= divz && is_div;
      end
      // A divide by zero still burns the full busy period but leaves HI/LO alone.
      if (commit && !p_divz) begin
        hi <= pend.hi;
        lo <= pend.lo;
      end
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table, directed corner sequences and randomized ops vs an arithmetic model.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiwe;
  logic        lowe;
  logic [31:0] wdata;
  logic        usemd_d;
  logic        kill;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  bit          viol = 1'b0;

  mdu_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdop    (mdop),
    .a       (a),
    .b       (b),
    .hiwe    (hiwe),
    .lowe    (lowe),
    .wdata   (wdata),
    .usemd_d (usemd_d),
    .kill    (kill),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset === 1'b0 && busy === 1'b1 && (start || hiwe || lowe)) viol <= 1'b1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ncyc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: MIPS HI/LO semantics computed with 64-bit integers.
  task automatic model_op(input logic [1:0] op, input logic [31:0] aa, input logic [31:0] bb);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     r;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    ua = {32'd0, aa};
    ub = {32'd0, bb};
    case (op)
      2'd0: begin r = sa * sb; hi_m = r[63:32]; lo_m = r[31:0]; end
      2'd1: begin r = ua * ub; hi_m = r[63:32]; lo_m = r[31:0]; end
      2'd2: if (bb != 0) begin
        r = sa / sb; lo_m = r[31:0];
        r = sa % sb; hi_m = r[31:0];
      end
      default: if (bb != 0) begin
        r = ua / ub; lo_m = r[31:0];
        r = ua % ub; hi_m = r[31:0];
      end
    endcase
  endtask

  task automatic wait_idle(output int n, output bit moved, input logic [31:0] hi0, input logic [31:0] lo0);
    n = 0;
    moved = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      if (hi !== hi0 || lo !== lo0) moved = 1'b1;
      n++;
      step();
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] aa,
                        input logic [31:0] bb, input int ncyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          n;
    bit          moved;
    hi0   = hi;
    lo0   = lo;
    mdop  = op;
    a     = aa;
    b     = bb;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(n, moved, hi0, lo0);
    chk({nm, ".cycles"}, n, ncyc);
    chk({nm, ".hold"}, {31'd0, moved}, 32'd0);
    chk({nm, ".hi"}, hi, ehi);
    chk({nm, ".lo"}, lo, elo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    bit          moved;
    logic [1:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    reset = 1'b1; start = 1'b0; hiwe = 1'b0; lowe = 1'b0; usemd_d = 1'b0;
    kill = 1'b0; mdop = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;

    vt[0] = '{md_mult,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vt[1] = '{md_multu, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
    vt[2] = '{md_div,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vt[3] = '{md_divu,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vt[4] = '{md_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vt[5] = '{md_divu,  32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, 10};
    vt[6] = '{md_div,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vt[7] = '{md_mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].ncyc, vt[i].ehi, vt[i].elo);
      model_op(vt[i].op, vt[i].a, vt[i].b);
    end

    // Stall from issue through the last busy cycle, then the product is readable.
    mdop = md_mult; a = 32'd5; b = 32'd7; start = 1'b1; usemd_d = 1'b1;
    #1;
    chk("stall.issue", {31'd0, stall}, 32'd1);
    step();
    start = 1'b0;
    n = 0;
    while (stall === 1'b1 && n < 20) begin n++; step(); end
    chk("stall.cycles", n, 5);
    usemd_d = 1'b0;
    model_op(md_mult, 32'd5, 32'd7);
    chk("stall.lo", lo, 32'd35);
    chk("stall.hi", hi, 32'd0);

    // mthi/mtlo back to back, then a killed mthi.
    hiwe = 1'b1; wdata = 32'h1234; step();
    hiwe = 1'b0; lowe = 1'b1; wdata = 32'h5678; step();
    lowe = 1'b0;
    chk("mt.hi", hi, 32'h1234);
    chk("mt.lo", lo, 32'h5678);
    hiwe = 1'b1; kill = 1'b1; wdata = 32'hDEAD; step();
    hiwe = 1'b0; kill = 1'b0;
    chk("mthi_kill.hi", hi, 32'h1234);
    hi_m = 32'h1234; lo_m = 32'h5678;

    // start together with mthi: the multiply wins, the write is dropped.
    mdop = md_multu; a = 32'd2; b = 32'd3; start = 1'b1; hiwe = 1'b1; wdata = 32'hBEEF;
    step();
    start = 1'b0; hiwe = 1'b0;
    wait_idle(n, moved, 32'h1234, 32'h5678);
    chk("start_mthi.cycles", n, 5);
    chk("start_mthi.hi", hi, 32'd0);
    chk("start_mthi.lo", lo, 32'd6);
    model_op(md_multu, 32'd2, 32'd3);

    // Killed issue does nothing.
    mdop = md_mult; a = 32'd3; b = 32'd3; start = 1'b1; kill = 1'b1; step();
    start = 1'b0; kill = 1'b0;
    chk("start_kill.busy", {31'd0, busy}, 32'd0);
    step();
    chk("start_kill.hi", hi, hi_m);
    chk("start_kill.lo", lo, lo_m);

    // kill during RUN does not abort the operation.
    mdop = md_mult; a = 32'h0001_0001; b = 32'h0001_0001; start = 1'b1; step();
    start = 1'b0; kill = 1'b1; step();
    kill = 1'b0;
    wait_idle(n, moved, hi_m, lo_m);
    chk("run_kill.cycles", n, 4);
    chk("run_kill.hi", hi, 32'h0000_0001);
    chk("run_kill.lo", lo, 32'h0002_0001);
    model_op(md_mult, 32'h0001_0001, 32'h0001_0001);

    // Asynchronous reset in busy cycle 3 of a divide.
    mdop = md_div; a = 32'd100; b = 32'd7; start = 1'b1; step();
    start = 1'b0; step(); step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.hi", hi, 32'd0);
    chk("arst.lo", lo, 32'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("arst_after.busy", {31'd0, busy}, 32'd0);
    chk("arst_after.hi", hi, 32'd0);
    chk("arst_after.lo", lo, 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;

    // Randomized ops and HI/LO writes against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4) begin
        op = 2'(sel);
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 7) == 0) rb = 32'd0;
        if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
        model_op(op, ra, rb);
        run_op($sformatf("rnd%0d", i), op, ra, rb, op[1] ? 10 : 5, hi_m, lo_m);
      end else begin
        wdata = $urandom;
        if (sel == 4) begin hiwe = 1'b1; hi_m = wdata; end
        else begin lowe = 1'b1; lo_m = wdata; end
        step();
        hiwe = 1'b0; lowe = 1'b0;
        chk($sformatf("rnd%0d.mt_hi", i), hi, hi_m);
        chk($sformatf("rnd%0d.mt_lo", i), lo, lo_m);
      end
    end

    step();
    chk("no_issue_while_busy", {31'd0, viol}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multiply/divide sequencer with architectural HI/LO registers, placed in the E stage of the five-stage MIPS pipeline beside the ALU. It accepts mult/multu/div/divu issues decoded by the control unit (`start`, `mdop`) and models the fixed MIPS latencies with a busy counter. It commits results to HI/LO, serves mthi/mtlo writes, and generates the D-stage stall for any HI/LO-using instruction while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: E-stage mult/multu/div/divu issue.
- `mdop` in 2: operation select, using the shared `md_*` encoding.
- `a`, `b` in 32: forwarded rs and rt operands in E.
- `hiwe`, `lowe` in 1: E-stage mthi/mtlo.
- `wdata` in 32: forwarded rs for mthi/mtlo.
- `usemd_d` in 1: the D-stage instruction uses the MDU (any of the 8 MDU instructions).
- `kill` in 1: E-stage instruction is flushed (exception/interrupt) this cycle.
- `busy` out 1: an operation is in flight.
- `stall` out 1: freeze F/D and bubble E.
- `hi`, `lo` out 32: architectural HI/LO. Read directly for mfhi/mflo.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, with a down-counter `cnt`.
- In IDLE, `start && !kill` does all of the following at that edge:
  - Compute the result and latch it into pending registers `p_hi`/`p_lo`.
  - Set `cnt` = N-1.
  - Go to RUN.
- RUN behaviour:
  - `cnt` decrements each cycle.
  - In the cycle with `cnt`==0, the edge writes `p_hi`/`p_lo` into HI/LO and returns to IDLE.
- Arithmetic:
  - mult: signed 32x32 to 64. multu: unsigned 32x32 to 64. HI = [63:32], LO = [31:0].
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend `a`.
  - divu: unsigned quotient and remainder.
  - `0x80000000` div `-1`: LO = `0x80000000`, HI = 0.
  - Divide by zero (`b`==0): full `DIV_CYCLES` busy period, HI/LO left unchanged.
- mthi/mtlo:
  - With `hiwe`/`lowe` && !`kill` in IDLE, the edge writes `wdata` to HI/LO.
  - Never while busy: the pipeline stalls those instructions upstream.
- `start` and `hiwe`/`lowe` together (illegal): `start` wins, the write is dropped.
- `start`/`hiwe`/`lowe` while `busy`: ignored, and the bench asserts this never happens.
- `kill`:
  - Suppresses `start`/`hiwe`/`lowe` in the same cycle only.
  - Does NOT abort an operation already in RUN.
- `stall` = `usemd_d && (busy || start)`. Purely combinational.

## Timing
- Reset values: `busy`=0, `stall`=0 (given `usemd_d`=0), `hi`=`lo`=0, `cnt`=0, state IDLE, `p_hi`=`p_lo`=0.
- Mult timeline, with `start` in cycle t:
  - `busy`=1 in cycles t+1..t+5.
  - HI/LO take the new value at the edge ending t+5 and are visible in t+6.
  - `busy`=0 in t+6.
- Div: the same timeline with 10 in place of 5.
- A D-stage MDU instruction in cycle t is stalled through t+N. It reaches E in t+N+1 and reads the new HI/LO.
- Back-to-back issue: `start` is accepted in the first cycle `busy`=0.
- Reset mid-RUN: immediate return to IDLE, pending result discarded, HI/LO cleared.

## Structure
- Shared include `head.v` gains:
  - `md_mult`=0, `md_multu`=1, `md_div`=2, `md_divu`=3.
  - `mdu_idle`/`mdu_run` state codes.
  - Default latency constants.
- One combinational sub-module `mdu_calc`: inputs (`mdop`, `a`, `b`), outputs (`r_hi`, `r_lo`, `divz`). It isolates the signed/unsigned and divide-by-zero arithmetic. The sequencing and HI/LO registers stay in `mdu_seq`.

## Test plan
1. `mult` a=`0xFFFFFFFE`, b=3:
   - `busy` high 5 cycles.
   - Then hi=`0xFFFFFFFF`, lo=`0xFFFFFFFA`.
   - Same operands with `multu`: hi=2, lo=`0xFFFFFFFA`.
2. `div` a=-7, b=2: lo=`0xFFFFFFFD`, hi=`0xFFFFFFFF` after exactly 10 busy cycles. `divu` a=7, b=0: HI/LO unchanged, `busy` still 10 cycles.
3. `mult` issued with `usemd_d`=1 in the same cycle:
   - `stall`=1 from issue through the 5th busy cycle, then drops.
   - The following mflo sees the product.
4. `mthi` `0x1234` then `mtlo` `0x5678` in consecutive cycles: hi=`0x1234`, lo=`0x5678`. `mthi` with `kill`=1: hi unchanged.
5. `start` with `kill`=1: `busy` stays 0 and HI/LO are unchanged. `kill` asserted during RUN: the result still commits on schedule.
6. `reset` asserted asynchronously in busy cycle 3 of a div: `busy`, hi and lo go to 0 immediately, and no commit follows.
